// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time loader. Receives a length-prefixed, XOR-checksummed
//            byte stream and writes the words into instruction memory. It
//            holds the processor in reset until a load completes with a
//            matching checksum.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [15:0] c_depth = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_len_hi;
    logic [ADDR_W:0]   r_len;        // word count; at most DEPTH so ADDR_W+1 bits suffice
    logic [ADDR_W:0]   r_word_cnt;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_asm;        // first three bytes of the word being assembled
    logic [7:0]        r_csum;
    logic              w_xfer;
    logic              w_clear;
    logic              w_word_done;
    logic [15:0]       w_len_full;

    // Stream handshake: ready only while the loader is consuming the stream
    always_comb begin
        in_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                   (r_state == S_DATA)   || (r_state == S_CHECK);
    end

    assign w_xfer     = in_valid && in_ready;
    assign w_len_full = {r_len_hi, in_data};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the clear / word-complete strobes
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_word_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LEN_HI;
                    w_clear     = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    // A zero or oversize length would leave memory ambiguous or wrap the address
                    if ((w_len_full == 16'd0) || (w_len_full > c_depth)) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && (r_byte_cnt == 2'd3)) begin
                    w_word_done = 1'b1;
                    if ((r_word_cnt + 1'b1) == r_len) w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_xfer) w_state_nxt = (in_data == r_csum) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_nxt = S_LEN_HI;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, write port and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_hi   <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_csum     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            // Status tracks the state being entered so it lines up with the state change
            cpu_reset <= (w_state_nxt != S_DONE);
            done      <= (w_state_nxt == S_DONE);
            error     <= (w_state_nxt == S_ERROR);

            if (w_clear) begin
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
                r_asm      <= '0;
                r_csum     <= '0;
            end
            if ((r_state == S_LEN_HI) && w_xfer) r_len_hi <= in_data;
            if ((r_state == S_LEN_LO) && w_xfer) r_len    <= w_len_full[ADDR_W:0];
            if ((r_state == S_DATA) && w_xfer) begin
                r_asm      <= {r_asm[15:0], in_data};
                r_csum     <= r_csum ^ in_data;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_word_done) begin
                imem_we    <= 1'b1;
                imem_addr  <= r_word_cnt[ADDR_W-1:0];
                imem_wdata <= {r_asm, in_data};
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader with a write
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int vectors     = 0;
    int miscompares = 0;

    // Expected writes: {addr, data}
    logic [ADDR_W+31:0] exp_q[$];

    logic [7:0] nom[11]  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                             8'hAC, 8'h08, 8'h00, 8'h54, 8'hDD};
    logic [7:0] one[7]   = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every write pulse cycle must match the next expected write
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                check("write_addr", 64'(imem_addr), 64'(e[ADDR_W+31:32]));
                check("write_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 16) begin
            @(negedge clk);
            t++;
        end
        check("ready_timeout", 64'(t < 16), 64'd1);
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic push_nom();
        exp_q.push_back({6'd0, 32'h20080005});
        exp_q.push_back({6'd1, 32'hAC080054});
    endtask

    // Called at the negedge after the final byte edge
    task automatic expect_end(input string tag, input logic d, input logic e, input logic cr);
        check({tag, "_done"},      64'(done),      64'(d));
        check({tag, "_error"},     64'(error),     64'(e));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(cr));
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check({tag, "_writes"},    64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),   64'd0);
        check("rst_we",        64'(imem_we),    64'd0);
        check("rst_addr",      64'(imem_addr),  64'd0);
        check("rst_wdata",     64'(imem_wdata), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset),  64'd1);
        check("rst_done",      64'(done),       64'd0);
        check("rst_error",     64'(error),      64'd0);
        reset = 1'b0;

        // Nominal load
        pulse_start();
        push_nom();
        for (int i = 0; i < 11; i++) send(nom[i]);
        gap(1);
        expect_end("nominal", 1'b1, 1'b0, 1'b0);

        // Bad checksum: writes still happen, then error
        pulse_start();
        push_nom();
        for (int i = 0; i < 10; i++) send(nom[i]);
        send(8'hDC);
        gap(1);
        expect_end("badsum", 1'b0, 1'b1, 1'b1);

        // Length 65 rejected, no writes
        pulse_start();
        send(8'h00);
        send(8'h41);
        gap(1);
        expect_end("len65", 1'b0, 1'b1, 1'b1);
        gap(4);
        check("len65_no_write", 64'(exp_q.size()), 64'd0);

        // Length 0 rejected
        pulse_start();
        send(8'h00);
        send(8'h00);
        gap(1);
        expect_end("len0", 1'b0, 1'b1, 1'b1);

        // Nominal stream with 3-cycle valid gaps
        pulse_start();
        push_nom();
        for (int i = 0; i < 11; i++) begin
            send(nom[i]);
            if (i != 10) gap(3);
        end
        gap(1);
        expect_end("gaps", 1'b1, 1'b0, 1'b0);

        // Reset after the 6th byte; the first word is written before reset lands
        pulse_start();
        exp_q.push_back({6'd0, 32'h20080005});
        for (int i = 0; i < 6; i++) send(nom[i]);
        @(negedge clk);
        reset    = 1'b1;
        in_data  = 8'hAC;
        in_valid = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midrst_in_ready",  64'(in_ready),   64'd0);
        check("midrst_cpu_reset", 64'(cpu_reset),  64'd1);
        check("midrst_we",        64'(imem_we),    64'd0);
        check("midrst_addr",      64'(imem_addr),  64'd0);
        check("midrst_wdata",     64'(imem_wdata), 64'd0);
        check("midrst_done",      64'(done),       64'd0);
        check("midrst_error",     64'(error),      64'd0);
        check("midrst_writes",    64'(exp_q.size()), 64'd0);
        pulse_start();
        push_nom();
        for (int i = 0; i < 11; i++) send(nom[i]);
        gap(1);
        expect_end("after_rst", 1'b1, 1'b0, 1'b0);

        // Restart from DONE, 1-word load with an ignored start during DATA
        pulse_start();
        check("restart_cpu_reset", 64'(cpu_reset), 64'd1);
        check("restart_done",      64'(done),      64'd0);
        check("restart_in_ready",  64'(in_ready),  64'd1);
        exp_q.push_back({6'd0, 32'h12345678});
        for (int i = 0; i < 4; i++) send(one[i]);
        pulse_start();
        for (int i = 4; i < 7; i++) send(one[i]);
        gap(1);
        expect_end("one_word", 1'b1, 1'b0, 1'b0);

        gap(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
